// File: rtl/handshake_pkg.sv
// Shared helpers for the handshake fabric: index width derivation and
// pointer arithmetic that wraps at an arbitrary modulus.
package handshake_pkg;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Index width for a given requester count, never narrower than one bit
  function automatic int idx_width(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  localparam int DEFAULT_NUM_INPUTS  = 4;
  localparam int DEFAULT_INDEX_WIDTH = idx_width(DEFAULT_NUM_INPUTS);

  // Increment a pointer, wrapping at limit rather than at a power of two
  function automatic int wrap_inc(input int value, input int limit);
    return ((value + 1) >= limit) ? 0 : (value + 1);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first valid requester at or after
// prio_ptr, scanning upward and wrapping at NUM_INPUTS.
module rr_priority_pick
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [NUM_INPUTS-1:0]  valid,
  input  logic [INDEX_WIDTH-1:0] prio_ptr,
  output logic [NUM_INPUTS-1:0]  grant_onehot,
  output logic [INDEX_WIDTH-1:0] grant_idx,
  output logic                   any_valid
);

  // Scan from the priority pointer; the first valid candidate wins
  always_comb begin
    int pos;
    logic [INDEX_WIDTH-1:0] cand;
    grant_onehot = '0;
    grant_idx    = '0;
    any_valid    = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      pos = int'(prio_ptr) + k;
      if (pos >= NUM_INPUTS) pos = pos - NUM_INPUTS;
      cand = INDEX_WIDTH'(pos);
      if (!any_valid && valid[cand]) begin
        any_valid          = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_arbiter_rr.sv
// Round-robin arbiter sharing one downstream handshake channel between
// NUM_INPUTS producers. Define HANDSHAKE_ARB_OUTREG_EN to add a one-slot
// output register; otherwise forwarding is combinational with a grant lock
// that keeps the offered token stable while downstream stalls.
module handshake_arbiter_rr
  import handshake_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = idx_width(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic [INDEX_WIDTH-1:0]           outs_index,
  output logic                             outs_valid,
  input  logic                             outs_ready
);

  logic [INDEX_WIDTH-1:0] prio_ptr_q, prio_ptr_d;
  logic [NUM_INPUTS-1:0]  pick_onehot;
  logic [INDEX_WIDTH-1:0] pick_idx;
  logic                   pick_any;
  logic [INDEX_WIDTH-1:0] grant;
  logic                   grant_valid;
  logic [DATA_WIDTH-1:0]  grant_data;

  rr_priority_pick #(
    .NUM_INPUTS  (NUM_INPUTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_pick (
    .valid        (ins_valid),
    .prio_ptr     (prio_ptr_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any_valid    (pick_any)
  );

`ifdef HANDSHAKE_ARB_OUTREG_EN

  logic                   full_q, full_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   slot_ready;
  logic                   in_fire;

  // The register holds the token, so the picker result is used directly
  always_comb begin
    grant       = pick_idx;
    grant_valid = pick_any;
    grant_data  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant == INDEX_WIDTH'(i)) grant_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
    end
    slot_ready = !full_q || outs_ready;
    in_fire    = grant_valid && slot_ready && !rst;
    ins_ready  = pick_onehot & {NUM_INPUTS{slot_ready && !rst}};
    outs_valid = full_q && !rst;
    outs       = data_q;
    outs_index = idx_q;
  end

  // Load on input transfer (possibly while unloading), drain on output transfer
  always_comb begin
    prio_ptr_d = prio_ptr_q;
    full_d     = full_q;
    data_d     = data_q;
    idx_d      = idx_q;
    if (in_fire) begin
      full_d     = 1'b1;
      data_d     = grant_data;
      idx_d      = grant;
      prio_ptr_d = INDEX_WIDTH'(wrap_inc(int'(grant), NUM_INPUTS));
    end else if (outs_ready) begin
      full_d = 1'b0;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q <= '0;
      full_q     <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
    end else begin
      prio_ptr_q <= prio_ptr_d;
      full_q     <= full_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
    end
  end

`else

  logic                   locked_q, locked_d;
  logic [INDEX_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic [NUM_INPUTS-1:0]  sel_onehot;
  logic                   out_fire;

  // Locked grant overrides the picker so a stalled token cannot be displaced
  always_comb begin
    grant       = locked_q ? lock_idx_q : pick_idx;
    grant_valid = locked_q ? 1'b0 : pick_any;
    sel_onehot  = locked_q ? '0 : pick_onehot;
    grant_data  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant == INDEX_WIDTH'(i)) begin
        grant_data = ins[i*DATA_WIDTH +: DATA_WIDTH];
        if (locked_q) begin
          grant_valid   = ins_valid[i];
          sel_onehot[i] = 1'b1;
        end
      end
    end
    outs_valid = grant_valid && !rst;
    outs       = grant_data;
    outs_index = grant;
    ins_ready  = sel_onehot & {NUM_INPUTS{outs_ready && grant_valid && !rst}};
    out_fire   = outs_valid && outs_ready;
  end

  // Advance priority past the winner on transfer; lock the grant on a stall
  always_comb begin
    prio_ptr_d = prio_ptr_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (out_fire) begin
      prio_ptr_d = INDEX_WIDTH'(wrap_inc(int'(grant), NUM_INPUTS));
      locked_d   = 1'b0;
    end else if (outs_valid) begin
      locked_d   = 1'b1;
      lock_idx_d = grant;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q <= '0;
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      prio_ptr_q <= prio_ptr_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`endif

endmodule

// File: tb/tb_handshake_arbiter_rr.sv
// Bench for handshake_arbiter_rr in its default combinational build:
// a 4-input instance driven against a scoreboard of expected grants, plus a
// 3-input instance exercising pointer wrap at a non-power-of-two count.
module tb_handshake_arbiter_rr;

  typedef struct {
    logic [31:0] data;
    logic [31:0] idx;
  } exp_t;

  logic        clk;
  logic        rst;

  logic [127:0] ins4;
  logic [3:0]   valid4;
  logic [3:0]   ready4;
  logic [31:0]  outs4;
  logic [1:0]   idx4;
  logic         ov4;
  logic         or4;

  logic [95:0]  ins3;
  logic [2:0]   valid3;
  logic [2:0]   ready3;
  logic [31:0]  outs3;
  logic [1:0]   idx3;
  logic         ov3;
  logic         or3;

  exp_t expQueue[$];
  int   checkCount;
  int   passCount;

  handshake_arbiter_rr #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(valid4), .ins_ready(ready4),
    .outs(outs4), .outs_index(idx4), .outs_valid(ov4), .outs_ready(or4)
  );

  handshake_arbiter_rr #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(valid3), .ins_ready(ready3),
    .outs(outs3), .outs_index(idx3), .outs_valid(ov3), .outs_ready(or3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive the 4-input instance and optionally queue the expected transfer
  task automatic applyStimulus(input logic [3:0] valid, input logic ready,
                               input bit expectXfer, input int expData, input int expIdx);
    exp_t e;
    valid4 = valid;
    or4    = ready;
    if (expectXfer) begin
      e.data = expData;
      e.idx  = expIdx;
      expQueue.push_back(e);
    end
  endtask

  task automatic toNegedge();
    @(negedge clk);
  endtask

  task automatic toNextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every observed output transfer must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov4 && or4) begin
      checkOutput("sb_pending", 32'(expQueue.size() != 0), 32'd1);
      if (expQueue.size() != 0) begin
        e = expQueue.pop_front();
        checkOutput("sb_data", outs4, e.data);
        checkOutput("sb_index", 32'(idx4), e.idx);
      end
    end
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int i = 0; i < 4; i++) ins4[i*32 +: 32] = 32'(100 + i);
    for (int i = 0; i < 3; i++) ins3[i*32 +: 32] = 32'(200 + i);
    valid3 = '0;
    or3    = 1'b0;
    rst    = 1'b1;
    applyStimulus(4'b1111, 1'b1, 0, 0, 0);
    toNegedge();
    checkOutput("reset_valid_forced_low", 32'(ov4), 32'd0);
    checkOutput("reset_ready_forced_low", 32'(ready4), 32'd0);
    toNextCycle();
    toNextCycle();
    rst = 1'b0;

    // Idle: nothing offered, nothing granted
    applyStimulus(4'b0000, 1'b1, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      toNegedge();
      checkOutput("idle_outs_valid", 32'(ov4), 32'd0);
      checkOutput("idle_ins_ready", 32'(ready4), 32'd0);
      toNextCycle();
    end

    // All requesting, downstream always ready: strict rotation
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1111, 1'b1, 1, 100 + (c % 4), c % 4);
      toNegedge();
      checkOutput("rotate_ready_onehot", 32'(ready4), 32'(1 << (c % 4)));
      toNextCycle();
    end

    // Only requester 3: pointer moves to 0 afterwards
    applyStimulus(4'b1000, 1'b1, 1, 103, 3);
    toNegedge();
    toNextCycle();

    // Stall on requester 1; requester 0 raises valid mid-stall but must not win
    applyStimulus(4'b0010, 1'b0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) applyStimulus(4'b0011, 1'b0, 0, 0, 0);
      toNegedge();
      checkOutput("stall_valid", 32'(ov4), 32'd1);
      checkOutput("stall_index", 32'(idx4), 32'd1);
      checkOutput("stall_data", outs4, 32'd101);
      checkOutput("stall_ready", 32'(ready4), 32'd0);
      toNextCycle();
    end
    applyStimulus(4'b0111, 1'b1, 1, 101, 1);
    toNegedge();
    checkOutput("release_ready", 32'(ready4), 32'b0010);
    toNextCycle();
    applyStimulus(4'b0111, 1'b1, 1, 102, 2);
    toNegedge();
    toNextCycle();
    applyStimulus(4'b0001, 1'b1, 1, 100, 0);
    toNegedge();
    toNextCycle();

    // Locked requester drops valid: lock persists, output goes invalid
    applyStimulus(4'b0010, 1'b0, 0, 0, 0);
    toNegedge();
    checkOutput("lock_setup_index", 32'(idx4), 32'd1);
    toNextCycle();
    applyStimulus(4'b0001, 1'b0, 0, 0, 0);
    toNegedge();
    checkOutput("violation_valid", 32'(ov4), 32'd0);
    toNextCycle();

    // Reset mid-lock: nothing emitted, then arbitration restarts at 0
    rst = 1'b1;
    applyStimulus(4'b0011, 1'b1, 0, 0, 0);
    toNegedge();
    checkOutput("midreset_valid", 32'(ov4), 32'd0);
    checkOutput("midreset_ready", 32'(ready4), 32'd0);
    toNextCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1, 100, 0);
    toNegedge();
    toNextCycle();
    applyStimulus(4'b0000, 1'b1, 0, 0, 0);

    // Three-input instance: wrap after requester 2 lands on requester 0
    valid3 = 3'b100;
    or3    = 1'b1;
    toNegedge();
    checkOutput("n3_last_index", 32'(idx3), 32'd2);
    checkOutput("n3_last_data", outs3, 32'd202);
    checkOutput("n3_last_ready", 32'(ready3), 32'b100);
    toNextCycle();
    valid3 = 3'b111;
    toNegedge();
    checkOutput("n3_wrap_index", 32'(idx3), 32'd0);
    checkOutput("n3_wrap_valid", 32'(ov3), 32'd1);
    toNextCycle();
    toNegedge();
    checkOutput("n3_next_index", 32'(idx3), 32'd1);
    toNextCycle();
    valid3 = '0;

    toNegedge();
    checkOutput("sb_drained", 32'(expQueue.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
